// File: rtl/acc_store_buffer.sv
// acc_store_buffer: DEPTH-entry FIFO draining ACC stores to data memory.
// Optional load forwarding when ACC_STORE_FWD_EN is defined.
module acc_store_buffer #(
  parameter int DATA_W = 11,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] Acc_i,
  input  logic [ADDR_W-1:0] Addr_i,
  input  logic              WrRam_i,
  output logic              Full_o,
  output logic              Empty_o,
  output logic [CW-1:0]     Count_o,
  output logic              Overflow_o,
  output logic              MemWr_o,
  output logic [ADDR_W-1:0] MemAddr_o,
  output logic [DATA_W-1:0] MemData_o,
  input  logic              MemReady_i,
  input  logic [ADDR_W-1:0] RdAddr_i,
  output logic              FwdHit_o,
  output logic [DATA_W-1:0] FwdData_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = WrRam_i && !full;
  assign pop   = !empty && MemReady_i;

  assign Full_o     = full;
  assign Empty_o    = empty;
  assign Count_o    = count;
  assign Overflow_o = overflow;
  assign MemWr_o    = !empty;
  assign MemAddr_o  = empty ? '0 : addr_q[rd_ptr];
  assign MemData_o  = empty ? '0 : data_q[rd_ptr];

  // Entry storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        addr_q[wr_ptr]  <= Addr_i;
        data_q[wr_ptr]  <= Acc_i;
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (WrRam_i && full)
        overflow <= 1'b1;
    end
  end

`ifdef ACC_STORE_FWD_EN
  logic [PW-1:0]     idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Scan oldest to newest so the youngest matching entry wins.
  always_comb begin
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == RdAddr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign FwdHit_o  = fwd_hit;
  assign FwdData_o = fwd_data;
`else
  logic unused_fwd;

  assign unused_fwd = ^{RdAddr_i, valid_q};
  assign FwdHit_o   = 1'b0;
  assign FwdData_o  = '0;
`endif

endmodule

// File: tb/tb_acc_store_buffer.sv
// tb_acc_store_buffer: directed stimulus with scoreboard-checked
// memory writes and direct status checks.
module tb_acc_store_buffer;

  localparam int DW = 11;
  localparam int AW = 11;
  localparam int CW = 3;

  logic          clock_i;
  logic          reset_n_i;
  logic [DW-1:0] Acc_i;
  logic [AW-1:0] Addr_i;
  logic          WrRam_i;
  logic          Full_o;
  logic          Empty_o;
  logic [CW-1:0] Count_o;
  logic          Overflow_o;
  logic          MemWr_o;
  logic [AW-1:0] MemAddr_o;
  logic [DW-1:0] MemData_o;
  logic          MemReady_i;
  logic [AW-1:0] RdAddr_i;
  logic          FwdHit_o;
  logic [DW-1:0] FwdData_o;

  acc_store_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .Acc_i      (Acc_i),
    .Addr_i     (Addr_i),
    .WrRam_i    (WrRam_i),
    .Full_o     (Full_o),
    .Empty_o    (Empty_o),
    .Count_o    (Count_o),
    .Overflow_o (Overflow_o),
    .MemWr_o    (MemWr_o),
    .MemAddr_o  (MemAddr_o),
    .MemData_o  (MemData_o),
    .MemReady_i (MemReady_i),
    .RdAddr_i   (RdAddr_i),
    .FwdHit_o   (FwdHit_o),
    .FwdData_o  (FwdData_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int passed = 0;
  int total  = 0;
  logic [AW+DW-1:0] sb [$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit accept);
    Addr_i  = a;
    Acc_i   = d;
    WrRam_i = 1'b1;
    if (accept) sb.push_back({a, d});
    tick();
    WrRam_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    MemReady_i = 1'b1;
    while (!Empty_o && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(Empty_o), 32'd1);
    MemReady_i = 1'b0;
  endtask

  // Monitor: a write accepted at the coming edge is checked against the queue.
  always @(negedge clock_i) begin
    logic [AW+DW-1:0] e;
    if (reset_n_i && MemWr_o && MemReady_i) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected none",
                 MemAddr_o, MemData_o);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(MemAddr_o), 32'(e[AW+DW-1:DW]));
        chk("wr_data", 32'(MemData_o), 32'(e[DW-1:0]));
      end
    end
  end

  initial begin
    reset_n_i  = 1'b0;
    Acc_i      = '0;
    Addr_i     = '0;
    WrRam_i    = 1'b0;
    MemReady_i = 1'b0;
    RdAddr_i   = '0;
    #3;
    chk("rst_full", 32'(Full_o), 32'd0);
    chk("rst_empty", 32'(Empty_o), 32'd1);
    chk("rst_count", 32'(Count_o), 32'd0);
    chk("rst_ovf", 32'(Overflow_o), 32'd0);
    chk("rst_memwr", 32'(MemWr_o), 32'd0);
    chk("rst_maddr", 32'(MemAddr_o), 32'd0);
    chk("rst_mdata", 32'(MemData_o), 32'd0);
    chk("rst_fwd", 32'(FwdHit_o), 32'd0);
    #9 reset_n_i = 1'b1;
    tick();

    push(11'd5, 11'd10, 1'b1);
    chk("one_memwr", 32'(MemWr_o), 32'd1);
    chk("one_addr", 32'(MemAddr_o), 32'd5);
    chk("one_data", 32'(MemData_o), 32'd10);
    chk("one_count", 32'(Count_o), 32'd1);
    tick();
    chk("one_hold", 32'(MemData_o), 32'd10);
    MemReady_i = 1'b1;
    tick();
    MemReady_i = 1'b0;
    chk("one_empty", 32'(Empty_o), 32'd1);
    chk("one_memwr0", 32'(MemWr_o), 32'd0);

    for (int i = 1; i <= 5; i++) begin
      push(AW'(19 + i), DW'(i), i <= 4);
      if (i == 3) chk("fill_notfull", 32'(Full_o), 32'd0);
      if (i == 4) chk("fill_full", 32'(Full_o), 32'd1);
    end
    chk("fill_ovf", 32'(Overflow_o), 32'd1);
    chk("fill_count", 32'(Count_o), 32'd4);

    Addr_i     = 11'd30;
    Acc_i      = 11'd9;
    WrRam_i    = 1'b1;
    MemReady_i = 1'b1;
    tick();
    WrRam_i = 1'b0;
    chk("fullpp_count", 32'(Count_o), 32'd3);
    chk("fullpp_ovf", 32'(Overflow_o), 32'd1);
    drain();
    chk("drain_ovf", 32'(Overflow_o), 32'd1);
    chk("drain_sb", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 3; i++)
      push(AW'(40 + i), DW'(100 + i), 1'b1);
    chk("mid_count", 32'(Count_o), 32'd3);
    MemReady_i = 1'b1;
    reset_n_i  = 1'b0;
    sb.delete();
    #1;
    chk("mid_count0", 32'(Count_o), 32'd0);
    chk("mid_memwr0", 32'(MemWr_o), 32'd0);
    chk("mid_empty", 32'(Empty_o), 32'd1);
    chk("mid_maddr", 32'(MemAddr_o), 32'd0);
    chk("mid_ovf0", 32'(Overflow_o), 32'd0);
    #1 reset_n_i = 1'b1;
    tick();
    tick();
    chk("mid_idle", 32'(MemWr_o), 32'd0);
    MemReady_i = 1'b0;
    push(11'd50, 11'd200, 1'b1);
    chk("restart_addr", 32'(MemAddr_o), 32'd50);
    chk("restart_data", 32'(MemData_o), 32'd200);
    drain();

    push(11'd7, 11'd3, 1'b1);
    push(11'd7, 11'd14, 1'b1);
    RdAddr_i = 11'd7;
    #1;
`ifdef ACC_STORE_FWD_EN
    chk("fwd_hit", 32'(FwdHit_o), 32'd1);
    chk("fwd_data", 32'(FwdData_o), 32'd14);
    RdAddr_i = 11'd8;
    #1;
    chk("fwd_miss", 32'(FwdHit_o), 32'd0);
    chk("fwd_miss_data", 32'(FwdData_o), 32'd0);
`else
    chk("nofwd_hit", 32'(FwdHit_o), 32'd0);
    chk("nofwd_data", 32'(FwdData_o), 32'd0);
`endif
    drain();
    chk("end_sb", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/acc_store_buffer.md
Name: acc_store_buffer

Overview:
- Consumer side of the accumulator: captures the ACC output value on every store (STO) instruction and drains it to data memory through a valid/ready write handshake.
- Sits between the ACC register and the data RAM, so the core never waits on memory write latency unless the buffer is full.
- Entries hold {address, data} in a DEPTH-entry circular FIFO, drained in program order.

Parameters:
DATA_W, 11, width of accumulator/data word
ADDR_W, 11, width of data-memory address
DEPTH, 4, number of buffer entries; power of 2, minimum 2

Ports:
clock_i  input  1  system clock, rising edge
reset_n_i  input  1  asynchronous active-low reset
Acc_i  input  DATA_W  current accumulator value (ACC output)
Addr_i  input  ADDR_W  store address from instruction operand
WrRam_i  input  1  store request from control unit
Full_o  output  1  buffer full; control unit must stall stores
Empty_o  output  1  no pending entries
Count_o  output  log2(DEPTH)+1  number of pending entries
Overflow_o  output  1  sticky: store request arrived while full
MemWr_o  output  1  write valid toward data memory
MemAddr_o  output  ADDR_W  head-entry address
MemData_o  output  DATA_W  head-entry data
MemReady_i  input  1  memory accepts write this cycle
RdAddr_i  input  ADDR_W  load address for forwarding check
FwdHit_o  output  1  RdAddr_i matches a pending entry
FwdData_o  output  DATA_W  forwarded data

Behaviour:
- Reset is asynchronous. While reset_n_i=0: count=0, pointers=0, all entries invalid, Full_o=0, Empty_o=1, Count_o=0, Overflow_o=0, MemWr_o=0, MemAddr_o=0, MemData_o=0, FwdHit_o=0, FwdData_o=0. Reset asserted mid-drain discards every pending entry; no further MemWr_o until new pushes.
- Push: WrRam_i=1 and Full_o=0 at a rising edge writes {Addr_i, Acc_i} at the write pointer, advances the pointer, and increments count.
- Pop: MemWr_o=1 and MemReady_i=1 at a rising edge advances the read pointer and decrements count.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Simultaneous push and pop when full: push rejected, since Full_o uses registered count. Pop proceeds.
- Pointers wrap modulo DEPTH.
- Store dropped while full: entry not written; Overflow_o set at that edge and held until reset.
- Outputs MemWr_o, Full_o, Empty_o and Count_o are all decoded from registered count:
  - MemWr_o = (count != 0)
  - Full_o = (count == DEPTH)
  - Empty_o = (count == 0)
  - Count_o = count
- MemAddr_o and MemData_o are driven from the head entry. When empty they are 0.
- Latency: push at edge N gives MemWr_o=1 after edge N, so memory can accept at edge N+1.
- MemWr_o, MemAddr_o and MemData_o hold stable while MemReady_i=0.
- DATA_W/ADDR_W values are stored unmodified; no arithmetic.

Optional Feature:
- Macro: ACC_STORE_FWD_EN
- Defined:
  - FwdHit_o is combinational: 1 when RdAddr_i equals the address of any valid entry.
  - FwdData_o is the data of the newest matching entry (closest to the write pointer).
  - The entry being pushed in the same cycle is not visible.
  - An entry popped in the same cycle is still visible.
  - FwdData_o=0 when there is no hit.
- Undefined: comparison logic is absent; FwdHit_o and FwdData_o are tied to 0, and ports remain.

Test Plan:
- Reset check: pulse reset_n_i low asynchronously between edges -> all outputs 0 immediately, Empty_o=1.
- Single store: Acc_i=11'd10, Addr_i=11'd5, WrRam_i=1 for one edge, MemReady_i=0 -> next cycle MemWr_o=1, MemAddr_o=5, MemData_o=10, Count_o=1. Raise MemReady_i -> after one edge, Empty_o=1 and MemWr_o=0.
- Fill and overflow: 5 stores (data 1..5, addr 20..24), MemReady_i=0 -> Full_o=1 after 4th; 5th dropped, Overflow_o=1. Then drain with MemReady_i=1 -> memory sees data 1,2,3,4 in order, addr 20..23; Overflow_o stays 1.
- Full with simultaneous push and pop: count=4, WrRam_i=1 with data 9, MemReady_i=1 -> count=3, data 9 not stored, Overflow_o=1.
- Reset mid-drain: 3 entries pending, assert reset_n_i low during a MemReady_i=1 cycle -> Count_o=0 and MemWr_o=0 at once; later pushes restart from pointer 0.
- With ACC_STORE_FWD_EN: stores (addr 7, data 3) then (addr 7, data 14), MemReady_i=0, RdAddr_i=7 -> FwdHit_o=1, FwdData_o=14. RdAddr_i=8 -> FwdHit_o=0. Without the macro -> FwdHit_o=0 always.
